cnt_arb_ctrl: RTL and testbench
===============================

# cnt_arb_ctrl

Round-robin controller that shares one up/down counter between several requesters. Each requester asks for a burst of N count steps in a chosen direction. The block grants one requester at a time, drives the counter's `act` and `up_dwn_n` controls for exactly N cycles, and reports completion. It sits between the requesting agents and the counter state machine, and it watches the counter's `count` and `ovflw` outputs to catch faults.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- COUNTER_WIDTH, 4, width of the controlled counter's `count`
- LEN_WIDTH, 4, width of each burst-length field

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester level request; held until its `done`
- req_up_dwn_n  in  NUM_REQ  per-requester direction (1 = up, 0 = down)
- req_len  in  NUM_REQ*LEN_WIDTH  per-requester burst length; requester i occupies bits [i*LEN_WIDTH +: LEN_WIDTH]
- gnt  out  NUM_REQ  one-hot grant, registered
- done  out  1  one-cycle pulse at burst completion, coincident with `gnt`
- err  out  1  sticky fault flag
- sat  out  1  one-cycle pulse when a burst is cut short by the saturation guard (guard only)
- cnt_act  out  1  to counter `act`, registered
- cnt_up_dwn_n  out  1  to counter `up_dwn_n`, registered
- cnt_count  in  COUNTER_WIDTH  from counter `count`
- cnt_ovflw  in  1  from counter `ovflw`

## Operation
- States: IDLE, RUN, DONE, FAULT.
- Reset values: state = IDLE; gnt = 0; done = 0; err = 0; sat = 0; cnt_act = 0; cnt_up_dwn_n = 1; round-robin pointer = requester 0; remaining = 0.
- IDLE with any `req` bit set:
  - Pick the first requester at or after the pointer, wrapping modulo NUM_REQ.
  - Latch its direction into `cnt_up_dwn_n` and its length into `remaining`.
  - Set `gnt` one-hot for that requester.
  - Advance the pointer to winner+1 (mod NUM_REQ).
  - Go to RUN if the length is nonzero; go straight to DONE if the length is 0 (no `cnt_act` is issued).
- RUN:
  - `cnt_act` = 1 each cycle; `remaining` decrements by 1 each cycle.
  - When `remaining` == 1, go to DONE.
  - Dropping `req` mid-burst is ignored; the burst completes.
- DONE:
  - For one cycle: `done` = 1, `cnt_act` = 0, `gnt` held.
  - Then go to IDLE and clear `gnt`.
- `cnt_ovflw` = 1 in any state: go to FAULT.
  - FAULT: `err` = 1, `gnt` = 0, `cnt_act` = 0.
  - Stay in FAULT until reset, because the counter's overflow is sticky until reset.
  - If overflow and the final RUN step occur in the same cycle, FAULT wins and no `done` is issued.
- Requests seen in IDLE while `err` = 1 are never granted.
- `remaining` is LEN_WIDTH bits and never underflows; a length of 0 never enters RUN.

## Timing
- `req` sampled high at edge k → `gnt` and the first `cnt_act` are high from edge k+1.
- A burst of L ≥ 1 gives exactly L consecutive `cnt_act` cycles; `done` is high in the cycle after the last `cnt_act`.
- Back-to-back bursts: at least one cycle with `cnt_act` = 0 (DONE) and one IDLE cycle. This guarantees the counter passes through its own IDLE between bursts.
- `cnt_ovflw` rising at edge k → `cnt_act` = 0 and `err` = 1 from edge k+1.
- Reset asserted mid-burst → all outputs return to their reset values immediately (asynchronous); the pointer returns to 0.

## Configuration
- Macro: `CNT_ARB_SATGUARD_EN`.
- Defined:
  - In RUN, before asserting `cnt_act`, check `cnt_count`.
  - If the direction is up and `cnt_count` == 2^COUNTER_WIDTH−1, or the direction is down and `cnt_count` == 0:
    - Do not assert `cnt_act`.
    - Pulse `sat` together with `done`.
    - Go to DONE.
  - The counter's overflow is therefore never provoked by this block.
- Undefined:
  - No guard; `sat` is tied to 0.
  - Reaching a counter boundary produces overflow, which leads to FAULT.

## Structure
- Shared package `cnt_arb_pkg`:
  - State encoding localparams (one-hot: IDLE = 4'b0001, RUN = 4'b0010, DONE = 4'b0100, FAULT = 4'b1000).
  - State width constant.
- Sub-module `cnt_rr_arb`: combinational round-robin pick (req vector + pointer → one-hot winner + valid), parameterized by NUM_REQ.
- The top holds the FSM, the pointer register, the length/direction latches and the guard logic.

## Test plan
- Reset, then req = 4'b0001, len0 = 3, up → `gnt` = 0001 one cycle after the request; `cnt_act` high for 3 cycles; `done` pulse on cycle 4; `gnt` = 0 on cycle 5.
- req = 4'b1111 held, all len = 1 → grants in order 0001, 0010, 0100, 1000, 0001; one `done` per grant; a `cnt_act` gap of ≥2 cycles between bursts.
- len1 = 0, req = 4'b0010 → `gnt` = 0010 and `done` together in the cycle after the request; no `cnt_act` at all.
- `cnt_ovflw` forced to 1 mid-burst of length 5 → next cycle `cnt_act` = 0, `gnt` = 0, `err` = 1; further requests are ignored until `rst_n` pulses low.
- With `CNT_ARB_SATGUARD_EN` defined: `cnt_count` = 4'hF, up burst of length 4 → no `cnt_act`; `sat` and `done` pulse; `err` stays 0. Without the macro, the same stimulus → `cnt_act` asserted, then FAULT once the counter raises `ovflw`.
- `rst_n` dropped during RUN → `cnt_act`, `gnt` and `done` go to 0 immediately; after release, the first grant goes to requester 0 when req = 4'b0011.

Source files
------------

// File: rtl/cnt_arb_pkg.sv
// Shared state encoding for the round-robin counter arbiter controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cnt_arb_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] IDLE_ENC  = 4'b0001;
    localparam logic [STATE_W-1:0] RUN_ENC   = 4'b0010;
    localparam logic [STATE_W-1:0] DONE_ENC  = 4'b0100;
    localparam logic [STATE_W-1:0] FAULT_ENC = 4'b1000;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = IDLE_ENC,
        ST_RUN   = RUN_ENC,
        ST_DONE  = DONE_ENC,
        ST_FAULT = FAULT_ENC
    } state_t;

endpackage

// File: rtl/cnt_rr_arb.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is consumed.
module cnt_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic               win_vld
);

    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [NUM_REQ-1:0] upper_mask;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] pick_src;

    // Requests at or above the pointer win first; otherwise wrap to the lowest.
    assign upper_mask = ~((ONE << ptr) - ONE);
    assign masked     = req & upper_mask;
    assign pick_src   = (masked != '0) ? masked : req;
    assign win_oh     = pick_src & (~pick_src + ONE);
    assign win_vld    = |req;

endmodule

// File: rtl/cnt_arb_ctrl.sv
// Round-robin burst controller for a shared up/down counter; CNT_ARB_SATGUARD_EN adds a boundary guard.
// Latency: req sampled at edge k -> gnt and first cnt_act from edge k+1; done one cycle after last cnt_act.
// Backpressure: req is a level held until done; other requesters wait for the DONE + IDLE gap.
module cnt_arb_ctrl
    import cnt_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int COUNTER_WIDTH = 4,
    parameter int LEN_WIDTH     = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_up_dwn_n,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]   req_len,
    output logic [NUM_REQ-1:0]             gnt,
    output logic                           done,
    output logic                           err,
    output logic                           sat,
    output logic                           cnt_act,
    output logic                           cnt_up_dwn_n,
    input  logic [COUNTER_WIDTH-1:0]       cnt_count,
    input  logic                           cnt_ovflw
);

    localparam int               PTR_W    = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    state_t                 state;
    logic [PTR_W-1:0]       ptr;
    logic [PTR_W-1:0]       win_idx;
    logic [PTR_W-1:0]       ptr_nxt;
    logic [NUM_REQ-1:0]     win_oh;
    logic                   arb_vld;
    logic                   win_dir;
    logic [LEN_WIDTH-1:0]   win_len;
    logic [LEN_WIDTH-1:0]   remaining;
    logic                   sat_q;
    logic                   lim_up;
    logic                   lim_dn;
    logic                   guard_new;
    logic                   guard_run;

    cnt_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req     (req),
        .ptr     (ptr),
        .win_oh  (win_oh),
        .win_vld (arb_vld)
    );

    // Steer the winner's index, length and direction out of the packed inputs.
    always_comb begin
        win_idx = '0;
        win_len = '0;
        win_dir = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                win_idx = PTR_W'(i);
                win_len = req_len[i*LEN_WIDTH +: LEN_WIDTH];
                win_dir = req_up_dwn_n[i];
            end
        end
    end

    assign ptr_nxt = (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);

`ifdef CNT_ARB_SATGUARD_EN
    assign lim_up = (cnt_count == {COUNTER_WIDTH{1'b1}});
    assign lim_dn = (cnt_count == '0);
    assign sat    = sat_q;
`else
    assign lim_up = 1'b0;
    assign lim_dn = 1'b0;
    assign sat    = 1'b0;
    logic unused_guard;
    assign unused_guard = sat_q ^ (^cnt_count);
`endif

    // guard_new judges a fresh grant's direction; guard_run the latched one.
    assign guard_new = win_dir      ? lim_up : lim_dn;
    assign guard_run = cnt_up_dwn_n ? lim_up : lim_dn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            gnt          <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            sat_q        <= 1'b0;
            cnt_act      <= 1'b0;
            cnt_up_dwn_n <= 1'b1;
            ptr          <= '0;
            remaining    <= '0;
        end else if (cnt_ovflw) begin
            // Counter overflow is sticky, so the fault is terminal until reset.
            state     <= ST_FAULT;
            err       <= 1'b1;
            gnt       <= '0;
            done      <= 1'b0;
            sat_q     <= 1'b0;
            cnt_act   <= 1'b0;
            remaining <= '0;
        end else begin
            done  <= 1'b0;
            sat_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt_act <= 1'b0;
                    if (arb_vld && !err) begin
                        gnt          <= win_oh;
                        cnt_up_dwn_n <= win_dir;
                        ptr          <= ptr_nxt;
                        if (win_len == '0) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            remaining <= '0;
                        end else if (guard_new) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            sat_q     <= 1'b1;
                            remaining <= '0;
                        end else begin
                            state     <= ST_RUN;
                            cnt_act   <= 1'b1;
                            remaining <= win_len;
                        end
                    end
                end
                ST_RUN: begin
                    if (remaining < LEN_WIDTH'(2)) begin
                        state     <= ST_DONE;
                        cnt_act   <= 1'b0;
                        done      <= 1'b1;
                        remaining <= '0;
                    end else if (guard_run) begin
                        state     <= ST_DONE;
                        cnt_act   <= 1'b0;
                        done      <= 1'b1;
                        sat_q     <= 1'b1;
                        remaining <= '0;
                    end else begin
                        cnt_act   <= 1'b1;
                        remaining <= remaining - LEN_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    gnt     <= '0;
                    cnt_act <= 1'b0;
                end
                ST_FAULT: begin
                    err     <= 1'b1;
                    gnt     <= '0;
                    cnt_act <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    gnt     <= '0;
                    cnt_act <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_arb_ctrl.sv
// Randomized bench for cnt_arb_ctrl against a burst-level round-robin model.
module tb_cnt_arb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  req_up_dwn_n = '0;
    logic [15:0] req_len = '0;
    logic [3:0]  gnt;
    logic        done;
    logic        err;
    logic        sat;
    logic        cnt_act;
    logic        cnt_up_dwn_n;
    logic [3:0]  cnt_count = 4'h5;
    logic        cnt_ovflw = 1'b0;

    int n_chk = 0;
    int n_err = 0;
    int ptr_m = 0;

    cnt_arb_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_up_dwn_n (req_up_dwn_n),
        .req_len      (req_len),
        .gnt          (gnt),
        .done         (done),
        .err          (err),
        .sat          (sat),
        .cnt_act      (cnt_act),
        .cnt_up_dwn_n (cnt_up_dwn_n),
        .cnt_count    (cnt_count),
        .cnt_ovflw    (cnt_ovflw)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference round-robin: first requester at or after the pointer, wrapping.
    function automatic int pick(input logic [3:0] rq, input int p);
        for (int off = 0; off < 4; off++) begin
            int i;
            i = (p + off) % 4;
            if (((rq >> i) & 4'd1) != 4'd0) return i;
        end
        return -1;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt"},  32'(gnt), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"},  32'(err), 0);
        chk({tag, "_sat"},  32'(sat), 0);
        chk({tag, "_act"},  32'(cnt_act), 0);
        chk({tag, "_dir"},  32'(cnt_up_dwn_n), 1);
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk_reset_vals(tag);
        @(negedge clk);
        rst_n = 1'b1;
        cnt_ovflw = 1'b0;
        req = '0;
        ptr_m = 0;
    endtask

    // One full arbitration round, starting from an IDLE cycle at a negedge.
    task automatic do_burst(input logic [3:0] rq, input logic [3:0] dirs,
                            input logic [15:0] lens, input bit drop);
        int w;
        logic [3:0] len;
        logic [3:0] oh;
        req = rq;
        req_up_dwn_n = dirs;
        req_len = lens;
        w = pick(rq, ptr_m);
        tick();
        if (w < 0) begin
            chk("noreq_gnt", 32'(gnt), 0);
            chk("noreq_act", 32'(cnt_act), 0);
            return;
        end
        len = 4'(lens >> (4 * w));
        oh = 4'b0001 << w;
        ptr_m = (w + 1) % 4;
        for (int c = 1; c <= int'(len); c++) begin
            chk("run_gnt", 32'(gnt), 32'(oh));
            chk("run_act", 32'(cnt_act), 1);
            chk("run_done", 32'(done), 0);
            chk("run_dir", 32'(cnt_up_dwn_n), 32'((dirs >> w) & 4'd1));
            if (drop) req = '0;
            tick();
        end
        chk("done_pulse", 32'(done), 1);
        chk("done_gnt", 32'(gnt), 32'(oh));
        chk("done_act", 32'(cnt_act), 0);
        chk("done_sat", 32'(sat), 0);
        req = '0;
        tick();
        chk("idle_gnt", 32'(gnt), 0);
        chk("idle_done", 32'(done), 0);
        chk("idle_act", 32'(cnt_act), 0);
    endtask

    // Start a burst, raise overflow on active cycle n_act, then confirm the lockout.
    task automatic do_fault(input logic [3:0] rq, input logic [15:0] lens, input int n_act);
        req = rq;
        req_up_dwn_n = 4'hF;
        req_len = lens;
        tick();
        for (int c = 1; c < n_act; c++) begin
            chk("pre_fault_act", 32'(cnt_act), 1);
            tick();
        end
        chk("pre_fault_act", 32'(cnt_act), 1);
        cnt_ovflw = 1'b1;
        tick();
        chk("fault_act", 32'(cnt_act), 0);
        chk("fault_gnt", 32'(gnt), 0);
        chk("fault_err", 32'(err), 1);
        chk("fault_done", 32'(done), 0);
        cnt_ovflw = 1'b0;
        req = 4'hF;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("locked_gnt", 32'(gnt), 0);
            chk("locked_act", 32'(cnt_act), 0);
            chk("locked_err", 32'(err), 1);
        end
        pulse_reset("fault_rst");
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single up burst of 3 from requester 0.
        do_burst(4'b0001, 4'b0001, 16'h0003, 1'b0);

        // All requesting with length 1: strict rotation.
        for (int k = 0; k < 5; k++)
            do_burst(4'b1111, 4'($urandom_range(0, 15)), 16'h1111, 1'b0);

        // Zero-length burst: grant and done together, no act.
        do_burst(4'b0010, 4'b0000, 16'h3303, 1'b0);

        // Maximum length, with requests dropped mid-burst.
        do_burst(4'b0100, 4'b0100, 16'h0F00, 1'b1);

        for (int k = 0; k < 40; k++) begin
            logic [15:0] lens;
            for (int j = 0; j < 4; j++)
                lens[4*j +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15))
                                                               : 4'($urandom_range(0, 5));
            do_burst(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), lens,
                     $urandom_range(0, 3) == 0);
        end

        // Overflow mid-burst and on the final step.
        do_fault(4'b0001, 16'h0005, 3);
        do_fault(4'b0010, 16'h0020, 2);

`ifdef CNT_ARB_SATGUARD_EN
        cnt_count = 4'hF;
        req = 4'b0001;
        req_up_dwn_n = 4'b0001;
        req_len = 16'h0004;
        tick();
        ptr_m = 1;
        chk("sat_act", 32'(cnt_act), 0);
        chk("sat_pulse", 32'(sat), 1);
        chk("sat_done", 32'(done), 1);
        chk("sat_gnt", 32'(gnt), 1);
        chk("sat_err", 32'(err), 0);
        req = '0;
        tick();
        chk("sat_clear", 32'(sat), 0);
        cnt_count = 4'h5;
`else
        cnt_count = 4'hF;
        req = 4'b0001;
        req_up_dwn_n = 4'b0001;
        req_len = 16'h0004;
        tick();
        chk("nosat_act", 32'(cnt_act), 1);
        chk("nosat_sat", 32'(sat), 0);
        cnt_ovflw = 1'b1;
        tick();
        chk("nosat_fault_act", 32'(cnt_act), 0);
        chk("nosat_fault_err", 32'(err), 1);
        pulse_reset("nosat_rst");
        cnt_count = 4'h5;
`endif
        @(negedge clk);

        // Reset asserted mid-burst; pointer must restart at requester 0.
        do_burst(4'b0010, 4'b0000, 16'h0010, 1'b0);
        req = 4'b0100;
        req_up_dwn_n = 4'b0000;
        req_len = 16'h0600;
        tick();
        tick();
        chk("mid_run_act", 32'(cnt_act), 1);
        pulse_reset("mid_rst");
        @(negedge clk);
        do_burst(4'b0011, 4'b0011, 16'h0022, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
